jam_cost_table: RTL and testbench
=================================

Name: jam_cost_table

Overview:
- Upstream stage of the job-assignment engine.
- Accepts an N×N worker/job cost matrix as a row-major valid/ready stream and stores it in a register file.
- Answers the engine's (W, J) cost lookups with a registered Cost one cycle later.
- Pulses `start` once a complete, well-formed matrix is loaded. The engine stays held off until the table is valid.

Parameters:
- N, 8, number of workers and jobs; matrix is N×N.
- CW, 7, cost entry width in bits.
- AW, 3, index width for W and J; must equal clog2(N).

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- clr  in  1  synchronous clear pulse; discards the table and returns to IDLE.
- in_valid  in  1  load beat valid.
- in_ready  out  1  block can accept a load beat.
- in_cost  in  CW  cost entry, row-major order: beat k goes to W = k/N, J = k%N.
- in_last  in  1  marks the final beat of the matrix.
- W  in  AW  worker index of the lookup.
- J  in  AW  job index of the lookup.
- Cost  out  CW  registered cost of the (W, J) pair sampled on the previous edge.
- table_ready  out  1  the stored matrix is complete and valid.
- start  out  1  one-cycle pulse that kicks the engine.
- load_err  out  1  sticky flag: in_last was misplaced or missing.

Behaviour:
- Reset (RST_N = 0 at an edge):
  - state = IDLE, beat counter = 0.
  - in_ready = 0, table_ready = 0, start = 0, load_err = 0, Cost = 0.
  - Storage contents are not cleared.
- States: IDLE, LOAD, FULL, ERR.
- Beat acceptance: a beat is accepted when in_valid && in_ready at the edge.
- IDLE:
  - in_ready = 1.
  - An accepted beat writes entry 0, sets counter = 1, and moves to LOAD.
  - If that first beat has in_last = 1 (only legal when N = 1): go to ERR.
- LOAD:
  - in_ready = 1.
  - Each accepted beat writes entry[counter], then counter increments.
  - Beat with counter = N*N-1 and in_last = 1: go to FULL.
  - Beat with counter = N*N-1 and in_last = 0: go to ERR.
  - Beat with counter < N*N-1 and in_last = 1: go to ERR; the beat is still written.
  - in_valid low: hold state and counter; no timeout.
- FULL:
  - in_ready = 0, table_ready = 1.
  - start is high for exactly the first cycle in FULL, i.e. the cycle after the final beat is accepted.
- ERR:
  - in_ready = 0, load_err = 1, table_ready = 0, start never asserts.
  - Only clr or reset leaves ERR.
- clr:
  - Valid in any state; goes to IDLE next edge, counter = 0, table_ready = 0, load_err = 0.
  - A beat presented in the same cycle as clr is not written: clr has priority over acceptance.
- Reset asserted mid-load: same as clr; the partial matrix is abandoned.
- Lookup:
  - Cost <= mem[W*N + J] on every edge, regardless of state.
  - Latency is exactly 1 cycle.
  - If table_ready = 0, Cost <= 0.
  - Same-cycle write and read of one entry returns the old value (read-before-write).
- Out-of-range indices (N not a power of two, W or J ≥ N): Cost <= 0.
- Address arithmetic: W*N + J computed at width 2*AW, with no wrap.

Decomposition:
- Shared package `jam_pkg` holds:
  - N, CW, AW.
  - Cost and index typedefs.
  - State encoding: IDLE = 2'd0, LOAD = 2'd1, FULL = 2'd2, ERR = 2'd3.
  - MAX_COST = 2**CW - 1.
- One natural sub-module: `jam_cost_rf`, an N*N×CW register file with one write port and one registered read port with zero-on-invalid. The FSM and handshake stay in the top level.

Test Plan:
1. Reset, then stream 64 beats in_cost = k%128 with in_last on beat 63 and in_valid always high → start pulses 1 cycle after beat 63; table_ready = 1; W = 3, J = 5 gives Cost = 29 one cycle later; W = 7, J = 7 gives Cost = 63.
2. Same load with in_valid low on every other cycle → beats written only on handshake; final table identical to scenario 1; start fires once.
3. in_last on beat 10 → load_err = 1 next cycle, in_ready = 0, no start; a following clr clears load_err and in_ready returns to 1.
4. 64 beats with no in_last → ERR after beat 63; table_ready stays 0; any W/J lookup returns Cost = 0.
5. clr asserted together with beat 30 → beat 30 not written, state IDLE; a full reload with all costs = 100 gives Cost = 100 at W = 3, J = 6.
6. RST_N low mid-load at beat 40, then a full reload of all-127 costs → table_ready = 1, W = 0, J = 0 gives Cost = 127, start pulses exactly once.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared constants, types and state encoding for the job-assignment cost table.
package jam_pkg;

    localparam int N     = 8;
    localparam int CW    = 7;
    localparam int AW    = 3;
    localparam int IW    = 2 * AW;
    localparam int DEPTH = N * N;

    typedef logic [CW-1:0] cost_t;
    typedef logic [AW-1:0] idx_t;
    typedef logic [IW-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam cost_t MAX_COST = cost_t'((1 << CW) - 1);
    localparam addr_t LAST_IDX = addr_t'(DEPTH - 1);

    // Row-major linear index, computed at full 2*AW width so it never wraps.
    function automatic addr_t lin_addr(input idx_t w, input idx_t j);
        return addr_t'(w) * addr_t'(N) + addr_t'(j);
    endfunction

endpackage

// File: rtl/jam_cost_rf.sv
// N*N cost register file: one write port, one registered read port that returns 0
// when the table is invalid or the index pair is out of range.
module jam_cost_rf
    import jam_pkg::*;
(
    input  logic  CLK,
    input  logic  RST_N,
    input  logic  wr_en,
    input  addr_t wr_addr,
    input  cost_t wr_data,
    input  logic  rd_valid,
    input  idx_t  rd_w,
    input  idx_t  rd_j,
    output cost_t rd_data
);

    cost_t mem [DEPTH];
    logic  in_range;

    assign in_range = (int'(rd_w) < N) && (int'(rd_j) < N);

    // Storage is deliberately not reset; a fresh load always rewrites every entry.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read alongside the write gives read-before-write on a collision.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_data <= '0;
        end else if (rd_valid && in_range) begin
            rd_data <= mem[lin_addr(rd_w, rd_j)];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/jam_cost_table.sv
// Loads a row-major N*N cost matrix from a valid/ready stream, flags framing errors,
// pulses start once the table is complete and serves registered (W, J) lookups.
module jam_cost_table
    import jam_pkg::*;
(
    input  logic  CLK,
    input  logic  RST_N,
    input  logic  clr,
    input  logic  in_valid,
    output logic  in_ready,
    input  cost_t in_cost,
    input  logic  in_last,
    input  idx_t  W,
    input  idx_t  J,
    output cost_t Cost,
    output logic  table_ready,
    output logic  start,
    output logic  load_err
);

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready are both
    // high; in_ready is registered and never depends on in_valid. clr and reset override
    // a transfer in the same cycle, so such a beat is dropped.
    state_t state;
    addr_t  cnt;
    logic   accept;
    logic   wr_en;

    assign accept = in_valid && in_ready;
    assign wr_en  = accept && !clr && RST_N;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            in_ready    <= 1'b0;
            table_ready <= 1'b0;
            start       <= 1'b0;
            load_err    <= 1'b0;
        end else if (clr) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            in_ready    <= 1'b1;
            table_ready <= 1'b0;
            start       <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                ST_IDLE, ST_LOAD: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        cnt <= cnt + addr_t'(1);
                        if (cnt == LAST_IDX) begin
                            in_ready <= 1'b0;
                            if (in_last) begin
                                state       <= ST_FULL;
                                table_ready <= 1'b1;
                                start       <= 1'b1;
                            end else begin
                                state    <= ST_ERR;
                                load_err <= 1'b1;
                            end
                        end else if (in_last) begin
                            state    <= ST_ERR;
                            in_ready <= 1'b0;
                            load_err <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_FULL: begin
                    in_ready    <= 1'b0;
                    table_ready <= 1'b1;
                end
                default: begin
                    in_ready    <= 1'b0;
                    table_ready <= 1'b0;
                    load_err    <= 1'b1;
                end
            endcase
        end
    end

    jam_cost_rf u_rf (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .wr_en    (wr_en),
        .wr_addr  (cnt),
        .wr_data  (in_cost),
        .rd_valid (table_ready),
        .rd_w     (W),
        .rd_j     (J),
        .rd_data  (Cost)
    );

endmodule

// File: tb/tb_jam_cost_table.sv
// Bench for jam_cost_table: scenario tasks with a reference copy of the matrix and a
// lookup scoreboard queue.
module tb_jam_cost_table;
    import jam_pkg::*;

    logic  CLK = 1'b0;
    logic  RST_N;
    logic  clr;
    logic  in_valid;
    logic  in_ready;
    cost_t in_cost;
    logic  in_last;
    idx_t  W;
    idx_t  J;
    cost_t Cost;
    logic  table_ready;
    logic  start;
    logic  load_err;

    int checks    = 0;
    int failures  = 0;
    int start_cnt = 0;

    logic [CW-1:0] exp_q[$];
    cost_t m_mem [DEPTH];
    int    m_cnt   = 0;
    logic  m_valid = 1'b0;

    jam_cost_table dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cost     (in_cost),
        .in_last     (in_last),
        .W           (W),
        .J           (J),
        .Cost        (Cost),
        .table_ready (table_ready),
        .start       (start),
        .load_err    (load_err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (start === 1'b1) start_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    function automatic cost_t beat_val(input int mode, input int k);
        case (mode)
            0:       return cost_t'(k % 128);
            1:       return cost_t'((k * 3) % 128);
            2:       return cost_t'(100);
            3:       return MAX_COST;
            default: return cost_t'(55);
        endcase
    endfunction

    function automatic cost_t model_cost(input int w, input int j);
        return m_valid ? m_mem[w * N + j] : '0;
    endfunction

    task automatic send_beat(input cost_t c, input logic last);
        int waitc = 0;
        in_valid = 1'b1;
        in_cost  = c;
        in_last  = last;
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge CLK);
            waitc++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL handshake in_ready=%b expected=1 beat=%0d", in_ready, m_cnt);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        @(negedge CLK);
        if (m_cnt < DEPTH) m_mem[m_cnt] = c;
        m_cnt++;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load_matrix(input int nbeats, input int last_at, input int mode, input int gap);
        for (int k = 0; k < nbeats; k++) begin
            if (gap != 0 && k > 0) begin
                in_valid = 1'b0;
                @(negedge CLK);
            end
            send_beat(beat_val(mode, k), k == last_at);
        end
    endtask

    task automatic lookup(input int w, input int j, input cost_t exp, input string name);
        cost_t got;
        cost_t e;
        W = idx_t'(w);
        J = idx_t'(j);
        exp_q.push_back(exp);
        @(negedge CLK);
        got = Cost;
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s W=%0d J=%0d Cost=%0d expected=%0d", name, w, j, got, e);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge CLK);
        clr     = 1'b0;
        m_cnt   = 0;
        m_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check_bit("reset_in_ready", in_ready, 1'b0);
        check_bit("reset_table_ready", table_ready, 1'b0);
        check_bit("reset_start", start, 1'b0);
        check_bit("reset_load_err", load_err, 1'b0);
        checks++;
        if (Cost !== '0) begin
            failures++;
            $display("FAIL reset_cost got=%0d expected=0", Cost);
        end
        RST_N = 1'b1;
        m_cnt = 0;
        m_valid = 1'b0;
        @(negedge CLK);
        check_bit("idle_in_ready", in_ready, 1'b1);
    endtask

    task automatic test_full_load();
        int sc0 = start_cnt;
        load_matrix(DEPTH, DEPTH - 1, 0, 0);
        check_bit("full_start_pulse", start, 1'b1);
        check_bit("full_table_ready", table_ready, 1'b1);
        check_bit("full_in_ready", in_ready, 1'b0);
        check_bit("full_load_err", load_err, 1'b0);
        m_valid = 1'b1;
        @(negedge CLK);
        check_bit("full_start_drop", start, 1'b0);
        lookup(3, 5, cost_t'(29), "full_w3_j5");
        lookup(7, 7, cost_t'(63), "full_w7_j7");
        for (int i = 0; i < 6; i++) begin
            int w = $urandom_range(0, N - 1);
            int j = $urandom_range(0, N - 1);
            lookup(w, j, model_cost(w, j), "full_random");
        end
        checks++;
        if (start_cnt - sc0 != 1) begin
            failures++;
            $display("FAIL full_start_count got=%0d expected=1", start_cnt - sc0);
        end
    endtask

    task automatic test_err_early_last();
        int sc0;
        do_clr();
        sc0 = start_cnt;
        load_matrix(11, 10, 1, 0);
        check_bit("early_last_load_err", load_err, 1'b1);
        check_bit("early_last_in_ready", in_ready, 1'b0);
        check_bit("early_last_start", start, 1'b0);
        check_bit("early_last_table_ready", table_ready, 1'b0);
        repeat (3) @(negedge CLK);
        lookup(3, 5, '0, "early_last_lookup");
        checks++;
        if (start_cnt != sc0) begin
            failures++;
            $display("FAIL early_last_start_count got=%0d expected=0", start_cnt - sc0);
        end
        do_clr();
        check_bit("early_last_clr_load_err", load_err, 1'b0);
        check_bit("early_last_clr_in_ready", in_ready, 1'b1);
    endtask

    task automatic test_err_no_last();
        int sc0 = start_cnt;
        load_matrix(DEPTH, -1, 1, 0);
        check_bit("no_last_load_err", load_err, 1'b1);
        check_bit("no_last_table_ready", table_ready, 1'b0);
        check_bit("no_last_in_ready", in_ready, 1'b0);
        @(negedge CLK);
        lookup(3, 5, '0, "no_last_w3_j5");
        lookup(7, 7, '0, "no_last_w7_j7");
        checks++;
        if (start_cnt != sc0) begin
            failures++;
            $display("FAIL no_last_start_count got=%0d expected=0", start_cnt - sc0);
        end
        do_clr();
    endtask

    task automatic test_clr_priority();
        int sc0;
        load_matrix(30, -1, 4, 0);
        in_valid = 1'b1;
        in_cost  = cost_t'(99);
        in_last  = 1'b0;
        clr      = 1'b1;
        @(negedge CLK);
        clr      = 1'b0;
        in_valid = 1'b0;
        m_cnt    = 0;
        m_valid  = 1'b0;
        check_bit("clr_beat_in_ready", in_ready, 1'b1);
        check_bit("clr_beat_table_ready", table_ready, 1'b0);
        check_bit("clr_beat_load_err", load_err, 1'b0);
        sc0 = start_cnt;
        load_matrix(DEPTH, DEPTH - 1, 2, 0);
        check_bit("clr_reload_start", start, 1'b1);
        check_bit("clr_reload_table_ready", table_ready, 1'b1);
        m_valid = 1'b1;
        @(negedge CLK);
        lookup(3, 6, cost_t'(100), "clr_reload_w3_j6");
        lookup(0, 0, model_cost(0, 0), "clr_reload_w0_j0");
        checks++;
        if (start_cnt - sc0 != 1) begin
            failures++;
            $display("FAIL clr_reload_start_count got=%0d expected=1", start_cnt - sc0);
        end
    endtask

    task automatic test_reset_midload();
        int sc0;
        do_clr();
        load_matrix(40, -1, 4, 0);
        RST_N    = 1'b0;
        in_valid = 1'b1;
        in_cost  = cost_t'(77);
        @(negedge CLK);
        check_bit("midreset_in_ready", in_ready, 1'b0);
        check_bit("midreset_table_ready", table_ready, 1'b0);
        in_valid = 1'b0;
        RST_N    = 1'b1;
        m_cnt    = 0;
        m_valid  = 1'b0;
        @(negedge CLK);
        sc0 = start_cnt;
        load_matrix(DEPTH, DEPTH - 1, 3, 0);
        check_bit("midreset_start", start, 1'b1);
        check_bit("midreset_table_ready_after", table_ready, 1'b1);
        m_valid = 1'b1;
        @(negedge CLK);
        lookup(0, 0, cost_t'(127), "midreset_w0_j0");
        lookup(7, 7, cost_t'(127), "midreset_w7_j7");
        checks++;
        if (start_cnt - sc0 != 1) begin
            failures++;
            $display("FAIL midreset_start_count got=%0d expected=1", start_cnt - sc0);
        end
    endtask

    task automatic test_gapped_load();
        int sc0;
        do_clr();
        sc0 = start_cnt;
        load_matrix(DEPTH, DEPTH - 1, 0, 1);
        check_bit("gapped_start", start, 1'b1);
        check_bit("gapped_table_ready", table_ready, 1'b1);
        m_valid = 1'b1;
        @(negedge CLK);
        for (int w = 0; w < N; w++) begin
            for (int j = 0; j < N; j++) begin
                lookup(w, j, model_cost(w, j), "gapped_table");
            end
        end
        lookup(3, 5, cost_t'(29), "gapped_w3_j5");
        checks++;
        if (start_cnt - sc0 != 1) begin
            failures++;
            $display("FAIL gapped_start_count got=%0d expected=1", start_cnt - sc0);
        end
        do_clr();
        lookup(3, 5, '0, "after_clr_lookup");
    endtask

    initial begin
        RST_N    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_cost  = '0;
        in_last  = 1'b0;
        W        = '0;
        J        = '0;
        test_reset();
        test_full_load();
        test_err_early_last();
        test_err_no_last();
        test_clr_priority();
        test_reset_midload();
        test_gapped_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
